// File: rtl/interface_ctrl.sv
// Board switch front-end plus channel selector that drives the LED bus.
// Latency: switch step to SW_STABLE in 2+DEBOUNCE_CYCLES cycles; SEL_OUT +1; RESTART +2.
// Backpressure: none; every output is a free-running register and CH_VALID is a plain strobe.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   SW                  raw switches: [0] soft clear, [1] hold, [2+:SEL_W] channel select
//   CH_DATA, CH_VALID   NUM_CH packed channels with per-channel sample strobes
//   SW_STABLE/RISE/FALL debounced switch levels and their one-cycle edge pulses
//   SEL_OUT, RESTART    applied channel index, one-cycle re-seed pulse for generators
//   LED                 displayed sample
module interface_ctrl #(
  parameter  int NUM_CH          = 4,
  parameter  int DATA_W          = 16,
  parameter  int DEBOUNCE_CYCLES = 512,
  localparam int SEL_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NUM_SW          = 2 + SEL_W
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_SW-1:0]          SW,
  input  logic [NUM_CH*DATA_W-1:0]   CH_DATA,
  input  logic [NUM_CH-1:0]          CH_VALID,
  output logic [NUM_SW-1:0]          SW_STABLE,
  output logic [NUM_SW-1:0]          SW_RISE,
  output logic [NUM_SW-1:0]          SW_FALL,
  output logic [SEL_W-1:0]           SEL_OUT,
  output logic                       RESTART,
  output logic [DATA_W-1:0]          LED
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0]             sync1_q, sync2_q;
  logic [NUM_SW-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SW-1:0]             stable_q, stable_d;
  logic [NUM_SW-1:0]             rise_q, rise_d;
  logic [NUM_SW-1:0]             fall_q, fall_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic                          sel_chg_q, sel_chg_d;
  logic                          restart_q, restart_d;
  logic [DATA_W-1:0]             led_q, led_d;

  logic [SEL_W-1:0]              sel_req;
  logic [DATA_W-1:0]             ch_arr [NUM_CH];

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreeing cycle restarts the count.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Out-of-range select codes (non-power-of-two NUM_CH) keep the old channel.
  always_comb begin
    sel_req = stable_q[2 +: SEL_W];
    sel_d   = (int'(sel_req) < NUM_CH) ? sel_req : sel_q;
    sel_chg_d = (sel_d != sel_q);
  end

  // sel_chg_q and rise_q[0] both mark "this cycle"; registering their OR gives
  // the pulse one cycle later, merging coincident causes into one pulse.
  assign restart_d = sel_chg_q | rise_q[0];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_arr[k] = CH_DATA[k*DATA_W +: DATA_W];
    end
  end

  // LED blanks on the same edge RESTART rises, so it reads 0 while RESTART is high.
  always_comb begin
    led_d = led_q;
    if (stable_q[0]) begin
      led_d = '0;
    end else if (restart_d) begin
      led_d = '0;
    end else if (stable_q[1]) begin
      led_d = led_q;
    end else if (CH_VALID[sel_q]) begin
      led_d = ch_arr[sel_q];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      sel_q     <= '0;
      sel_chg_q <= 1'b0;
      restart_q <= 1'b0;
      led_q     <= '0;
    end else begin
      sync1_q   <= SW;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
      restart_q <= restart_d;
      led_q     <= led_d;
    end
  end

  assign SW_STABLE = stable_q;
  assign SW_RISE   = rise_q;
  assign SW_FALL   = fall_q;
  assign SEL_OUT   = sel_q;
  assign RESTART   = restart_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_interface_ctrl.sv
// Directed bench for interface_ctrl with NUM_CH=4, DATA_W=16, DEBOUNCE_CYCLES=8.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Each scenario task carries its own hand-derived expectations.
module tb_interface_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  SW;
  logic [63:0] CH_DATA;
  logic [3:0]  CH_VALID;
  logic [3:0]  SW_STABLE, SW_RISE, SW_FALL;
  logic [1:0]  SEL_OUT;
  logic        RESTART;
  logic [15:0] LED;

  int total = 0;
  int bad   = 0;

  interface_ctrl #(.NUM_CH(4), .DATA_W(16), .DEBOUNCE_CYCLES(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .CH_DATA(CH_DATA), .CH_VALID(CH_VALID),
    .SW_STABLE(SW_STABLE), .SW_RISE(SW_RISE), .SW_FALL(SW_FALL),
    .SEL_OUT(SEL_OUT), .RESTART(RESTART), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    CH_DATA[k*16 +: 16] = v;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; SW = '0; CH_DATA = '0; CH_VALID = '0;
    ticks(3);
    total++; if (SW_STABLE !== 4'h0) begin bad++; $display("FAIL rst_stable got=%h exp=0", SW_STABLE); end
    total++; if (SW_RISE !== 4'h0 || SW_FALL !== 4'h0) begin bad++; $display("FAIL rst_edges rise=%h fall=%h exp=0", SW_RISE, SW_FALL); end
    total++; if (SEL_OUT !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", SEL_OUT); end
    total++; if (RESTART !== 1'b0) begin bad++; $display("FAIL rst_restart got=%b exp=0", RESTART); end
    total++; if (LED !== 16'h0) begin bad++; $display("FAIL rst_led got=%h exp=0", LED); end
    RST_N = 1'b1;
    ticks(4);
    total++; if ({SW_STABLE, SEL_OUT, RESTART, LED} !== '0) begin bad++; $display("FAIL idle_outputs stable=%h sel=%0d rst=%b led=%h exp all 0", SW_STABLE, SEL_OUT, RESTART, LED); end
  endtask

  task automatic test_select_step();
    set_ch(1, 16'h1111);
    SW = 4'b0100;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (SW_STABLE !== 4'b0000) begin bad++; $display("FAIL step_early cyc=%0d stable=%h exp=0", i, SW_STABLE); end
    end
    tick();
    total++; if (SW_STABLE !== 4'b0100) begin bad++; $display("FAIL step_stable got=%h exp=4", SW_STABLE); end
    total++; if (SW_RISE !== 4'b0100) begin bad++; $display("FAIL step_rise got=%h exp=4", SW_RISE); end
    tick();
    total++; if (SW_RISE !== 4'b0000) begin bad++; $display("FAIL step_rise_len got=%h exp=0", SW_RISE); end
    total++; if (SEL_OUT !== 2'd1) begin bad++; $display("FAIL step_sel got=%0d exp=1", SEL_OUT); end
    total++; if (RESTART !== 1'b0) begin bad++; $display("FAIL step_restart_early got=%b exp=0", RESTART); end
    CH_VALID = 4'b0010;
    tick();
    total++; if (RESTART !== 1'b1) begin bad++; $display("FAIL step_restart got=%b exp=1", RESTART); end
    total++; if (LED !== 16'h0) begin bad++; $display("FAIL step_led_blank got=%h exp=0", LED); end
    tick();
    total++; if (LED !== 16'h1111) begin bad++; $display("FAIL step_led_ch1 got=%h exp=1111", LED); end
    total++; if (RESTART !== 1'b0) begin bad++; $display("FAIL step_restart_len got=%b exp=0", RESTART); end
    CH_VALID = 4'b0000;
  endtask

  task automatic test_glitch();
    SW = 4'b1100;
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 7) SW = 4'b0100;
      total++; if (SW_STABLE !== 4'b0100 || SW_RISE !== 4'b0 || RESTART !== 1'b0) begin
        bad++; $display("FAIL glitch_reject cyc=%0d stable=%h rise=%h rst=%b exp 4/0/0", i, SW_STABLE, SW_RISE, RESTART);
      end
    end
    SW = 4'b1100;
    ticks(10);
    total++; if (SW_STABLE !== 4'b1100 || SW_RISE !== 4'b1000) begin bad++; $display("FAIL glitch_accept stable=%h rise=%h exp c/8", SW_STABLE, SW_RISE); end
    tick();
    total++; if (SEL_OUT !== 2'd3) begin bad++; $display("FAIL glitch_sel got=%0d exp=3", SEL_OUT); end
    tick();
    total++; if (RESTART !== 1'b1) begin bad++; $display("FAIL glitch_restart got=%b exp=1", RESTART); end
    SW = 4'b0000;
    ticks(10);
    total++; if (SW_FALL !== 4'b1100 || SW_STABLE !== 4'b0000) begin bad++; $display("FAIL back_fall fall=%h stable=%h exp c/0", SW_FALL, SW_STABLE); end
    ticks(3);
    total++; if (SEL_OUT !== 2'd0) begin bad++; $display("FAIL back_sel got=%0d exp=0", SEL_OUT); end
  endtask

  task automatic test_hold();
    set_ch(0, 16'h00AA);
    CH_VALID = 4'b0001;
    tick();
    CH_VALID = 4'b0000;
    total++; if (LED !== 16'h00AA) begin bad++; $display("FAIL hold_load got=%h exp=00aa", LED); end
    SW = 4'b0010;
    ticks(10);
    total++; if (SW_STABLE !== 4'b0010) begin bad++; $display("FAIL hold_stable got=%h exp=2", SW_STABLE); end
    tick();
    set_ch(0, 16'h5555);
    CH_VALID = 4'b0001;
    tick();
    CH_VALID = 4'b0000;
    total++; if (LED !== 16'h00AA) begin bad++; $display("FAIL hold_freeze got=%h exp=00aa", LED); end
    SW = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 10) begin
        total++; if (SW_FALL !== 4'b0010) begin bad++; $display("FAIL hold_fall got=%h exp=2", SW_FALL); end
      end
      total++; if (RESTART !== 1'b0) begin bad++; $display("FAIL hold_no_restart cyc=%0d got=%b exp=0", i, RESTART); end
    end
    CH_VALID = 4'b0001;
    tick();
    total++; if (LED !== 16'h5555 || RESTART !== 1'b0) begin bad++; $display("FAIL hold_resume led=%h rst=%b exp 5555/0", LED, RESTART); end
  endtask

  task automatic test_soft_clear();
    int pulses;
    SW = 4'b0001;
    ticks(10);
    total++; if (SW_RISE !== 4'b0001 || LED !== 16'h5555) begin bad++; $display("FAIL clr_rise rise=%h led=%h exp 1/5555", SW_RISE, LED); end
    pulses = 0;
    for (int i = 11; i <= 16; i++) begin
      tick();
      if (RESTART === 1'b1) pulses++;
      if (i == 11) begin
        total++; if (RESTART !== 1'b1) begin bad++; $display("FAIL clr_restart got=%b exp=1", RESTART); end
      end
      total++; if (LED !== 16'h0) begin bad++; $display("FAIL clr_led cyc=%0d got=%h exp=0", i, LED); end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL clr_pulse_count got=%0d exp=1", pulses); end
    SW = 4'b0000;
    CH_VALID = 4'b0000;
    pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (RESTART === 1'b1) pulses++;
      if (i == 10) begin
        total++; if (SW_FALL !== 4'b0001) begin bad++; $display("FAIL clr_fall got=%h exp=1", SW_FALL); end
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL clr_release_restart got=%0d exp=0", pulses); end
  endtask

  task automatic test_nonselected();
    int pulses;
    int at;
    SW = 4'b1000;
    ticks(12);
    total++; if (SEL_OUT !== 2'd2) begin bad++; $display("FAIL ns_sel got=%0d exp=2", SEL_OUT); end
    tick();
    set_ch(2, 16'h2222);
    CH_VALID = 4'b0100;
    tick();
    total++; if (LED !== 16'h2222) begin bad++; $display("FAIL ns_load got=%h exp=2222", LED); end
    set_ch(3, 16'hBEEF);
    set_ch(2, 16'h7777);
    CH_VALID = 4'b1000;
    tick();
    CH_VALID = 4'b0000;
    total++; if (LED !== 16'h2222) begin bad++; $display("FAIL ns_ignore got=%h exp=2222", LED); end
    // select change lands on the same cycle as SW_RISE[0]
    SW = 4'b1100;
    tick();
    SW = 4'b1101;
    pulses = 0; at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (RESTART === 1'b1) begin pulses++; at = i; end
    end
    total++; if (pulses != 1 || at != 11) begin bad++; $display("FAIL sim_restart pulses=%0d at=%0d exp 1 at 11", pulses, at); end
    total++; if (SEL_OUT !== 2'd3 || LED !== 16'h0) begin bad++; $display("FAIL sim_state sel=%0d led=%h exp 3/0", SEL_OUT, LED); end
  endtask

  task automatic test_async_reset();
    SW = 4'b1000;
    ticks(12);
    set_ch(2, 16'h1234);
    CH_VALID = 4'b0100;
    tick();
    CH_VALID = 4'b0000;
    total++; if (LED !== 16'h1234 || SEL_OUT !== 2'd2) begin bad++; $display("FAIL ar_preload led=%h sel=%0d exp 1234/2", LED, SEL_OUT); end
    SW = 4'b0001;
    ticks(5);
    #2 RST_N = 1'b0;
    #1;
    total++; if (LED !== 16'h0 || SEL_OUT !== 2'd0 || SW_STABLE !== 4'h0) begin bad++; $display("FAIL ar_async led=%h sel=%0d stable=%h exp 0", LED, SEL_OUT, SW_STABLE); end
    ticks(2);
    RST_N = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (SW_STABLE !== 4'b0000) begin bad++; $display("FAIL ar_partial cyc=%0d stable=%h exp=0", i, SW_STABLE); end
    end
    tick();
    total++; if (SW_STABLE !== 4'b0001) begin bad++; $display("FAIL ar_recount got=%h exp=1", SW_STABLE); end
  endtask

  initial begin
    test_reset();
    test_select_step();
    test_glitch();
    test_hold();
    test_soft_clear();
    test_nonselected();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
